// File: rtl/uart_tx_fifo.sv
// UART transmitter with a small word FIFO in front of it.
// Frame format: start, DATA_BITS data bits (LSB first), optional parity, STOP_BITS stop bits.
module uart_tx_fifo #(
   parameter int unsigned CLK_FREQ   = 50000000,
   parameter int unsigned BAUD       = 115200,
   parameter int unsigned DATA_BITS  = 8,
   parameter int unsigned STOP_BITS  = 1,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          tx_valid,
   input  logic [DATA_BITS-1:0]          tx_data,
   output logic                          tx_ready,
   input  logic [1:0]                    parity_mode,
   output logic                          TxD,
   output logic                          TxD_busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

   localparam int unsigned DIV    = (CLK_FREQ + BAUD / 2) / BAUD;
   localparam int unsigned BAUD_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W  = PTR_W + 1;
   localparam int unsigned IDX_W  = $clog2(DATA_BITS);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } fsmState_t;

   fsmState_t             state;
   fsmState_t             stateNext;

   logic [DATA_BITS-1:0]  mem [FIFO_DEPTH];
   logic [PTR_W-1:0]      wrPtr;
   logic [PTR_W-1:0]      rdPtr;
   logic [CNT_W-1:0]      countNext;
   logic [DATA_BITS-1:0]  headWord;
   logic                  fifoNotEmpty;
   logic                  pushFifo;
   logic                  popFifo;

   logic [BAUD_W-1:0]     baudCnt;
   logic                  baudTick;
   logic [DATA_BITS-1:0]  shiftReg;
   logic [IDX_W-1:0]      bitIdx;
   logic                  stopIdx;
   logic                  lastBit;
   logic                  lastStop;
   logic                  parityEn;
   logic                  parityBit;
   logic                  txdNext;

   assign headWord     = mem[rdPtr];
   assign fifoNotEmpty = (fifo_count != CNT_W'(0));
   assign pushFifo     = tx_valid && tx_ready;
   assign baudTick     = (state != IDLE) && (baudCnt == BAUD_W'(DIV - 1));
   assign lastBit      = (bitIdx == IDX_W'(DATA_BITS - 1));
   assign lastStop     = (stopIdx == 1'(STOP_BITS - 1));

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= stateNext;
      end
   end

   // Next state, pop request and line level for the current bit
   always_comb begin
      stateNext = state;
      popFifo   = 1'b0;
      txdNext   = 1'b1;
      case (state)
         IDLE: begin
            if (fifoNotEmpty) begin
               popFifo   = 1'b1;
               stateNext = START;
            end
         end
         START: begin
            txdNext = 1'b0;
            if (baudTick) begin
               stateNext = DATA;
            end
         end
         DATA: begin
            txdNext = shiftReg[0];
            if (baudTick && lastBit) begin
               stateNext = parityEn ? PARITY : STOP;
            end
         end
         PARITY: begin
            txdNext = parityBit;
            if (baudTick) begin
               stateNext = STOP;
            end
         end
         STOP: begin
            txdNext = 1'b1;
            if (baudTick && lastStop) begin
               // Back-to-back frames: pop on the last stop tick with no idle gap
               if (fifoNotEmpty) begin
                  popFifo   = 1'b1;
                  stateNext = START;
               end else begin
                  stateNext = IDLE;
               end
            end
         end
         default: begin
            stateNext = IDLE;
         end
      endcase
   end

   // FIFO occupancy after this cycle's push/pop
   always_comb begin
      countNext = fifo_count;
      case ({pushFifo, popFifo})
         2'b10:   countNext = fifo_count + CNT_W'(1);
         2'b01:   countNext = fifo_count - CNT_W'(1);
         default: countNext = fifo_count;
      endcase
   end

   // FIFO storage; contents need no reset since pointers define validity
   always_ff @(posedge clk) begin
      if (pushFifo) begin
         mem[wrPtr] <= tx_data;
      end
   end

   // FIFO pointers, count and registered ready
   always_ff @(posedge clk) begin
      if (rst) begin
         wrPtr      <= '0;
         rdPtr      <= '0;
         fifo_count <= '0;
         tx_ready   <= 1'b1;
      end else begin
         if (pushFifo) begin
            wrPtr <= wrPtr + PTR_W'(1);
         end
         if (popFifo) begin
            rdPtr <= rdPtr + PTR_W'(1);
         end
         fifo_count <= countNext;
         tx_ready   <= (countNext != CNT_W'(FIFO_DEPTH));
      end
   end

   // Baud counter, parked at zero while idle
   always_ff @(posedge clk) begin
      if (rst || (state == IDLE)) begin
         baudCnt <= '0;
      end else if (baudTick) begin
         baudCnt <= '0;
      end else begin
         baudCnt <= baudCnt + BAUD_W'(1);
      end
   end

   // Shift register, bit/stop indices and parity latched at pop
   always_ff @(posedge clk) begin
      if (rst) begin
         shiftReg  <= '0;
         bitIdx    <= '0;
         stopIdx   <= 1'b0;
         parityEn  <= 1'b0;
         parityBit <= 1'b0;
      end else if (popFifo) begin
         shiftReg  <= headWord;
         bitIdx    <= '0;
         stopIdx   <= 1'b0;
         parityEn  <= (parity_mode == 2'b01) || (parity_mode == 2'b10);
         parityBit <= (parity_mode == 2'b01) ? ~(^headWord) : (^headWord);
      end else if (baudTick) begin
         if (state == DATA) begin
            shiftReg <= shiftReg >> 1;
            bitIdx   <= bitIdx + IDX_W'(1);
         end
         if (state == STOP) begin
            stopIdx <= stopIdx + 1'b1;
         end
      end
   end

   // Registered line outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         TxD      <= 1'b1;
         TxD_busy <= 1'b0;
      end else begin
         TxD      <= txdNext;
         TxD_busy <= (state != IDLE);
      end
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: frame table (8-bit and 7N2 instances) plus
// burst/full and reset-mid-frame sequences. DIV = 10 clocks per bit throughout.
module tb_uart_tx_fifo;

   localparam int unsigned CLK_FREQ = 1000000;
   localparam int unsigned BAUD     = 100000;
   localparam int          DIV      = 10;

   logic       clk = 1'b0;
   logic       rst;

   logic       txValidA;
   logic [7:0] txDataA;
   logic       txReadyA;
   logic [1:0] parityModeA;
   logic       txdA;
   logic       busyA;
   logic [2:0] countA;

   logic       txValidB;
   logic [6:0] txDataB;
   logic       txReadyB;
   logic [1:0] parityModeB;
   logic       txdB;
   logic       busyB;
   logic [2:0] countB;

   int nCompared   = 0;
   int nMismatched = 0;

   always #5 clk = ~clk;

   uart_tx_fifo #(
      .CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DATA_BITS(8), .STOP_BITS(1), .FIFO_DEPTH(4)
   ) dutA (
      .clk(clk), .rst(rst), .tx_valid(txValidA), .tx_data(txDataA), .tx_ready(txReadyA),
      .parity_mode(parityModeA), .TxD(txdA), .TxD_busy(busyA), .fifo_count(countA)
   );

   uart_tx_fifo #(
      .CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DATA_BITS(7), .STOP_BITS(2), .FIFO_DEPTH(4)
   ) dutB (
      .clk(clk), .rst(rst), .tx_valid(txValidB), .tx_data(txDataB), .tx_ready(txReadyB),
      .parity_mode(parityModeB), .TxD(txdB), .TxD_busy(busyB), .fifo_count(countB)
   );

   typedef struct {
      int          which;
      logic [7:0]  data;
      logic [1:0]  mode;
      int          nBits;
      logic [10:0] line;   // line[i] is the i-th bit on TxD, start bit first
      string       name;
   } vec_t;

   vec_t vecs [10];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nCompared++;
      if (act !== exp) begin
         nMismatched++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic logic txdOf(input int w);
      return (w == 0) ? txdA : txdB;
   endfunction

   function automatic logic busyOf(input int w);
      return (w == 0) ? busyA : busyB;
   endfunction

   // Write one word, then check latency, every bit mid-bit and frame length
   task automatic runVec(input vec_t v);
      int k;
      int cyc;
      @(negedge clk);
      if (v.which == 0) begin
         txDataA = v.data; parityModeA = v.mode; txValidA = 1'b1;
      end else begin
         txDataB = v.data[6:0]; parityModeB = v.mode; txValidB = 1'b1;
      end
      @(negedge clk);
      txValidA = 1'b0;
      txValidB = 1'b0;
      k = 0;
      while (txdOf(v.which) !== 1'b0 && k < 50) begin
         @(negedge clk);
         k++;
      end
      check({v.name, "_latency"}, k, 2);
      check({v.name, "_busy_rise"}, busyOf(v.which), 1'b1);
      // Mid-frame mode change must not alter this frame
      if (v.which == 0) parityModeA = (v.mode == 2'b00 || v.mode == 2'b11) ? 2'b10 : 2'b00;
      else parityModeB = 2'b01;
      cyc = 0;
      for (int i = 0; i < v.nBits; i++) begin
         while (cyc < i * DIV + 5) begin
            @(negedge clk);
            cyc++;
         end
         check($sformatf("%s_bit%0d", v.name, i), txdOf(v.which), v.line[i]);
      end
      while (busyOf(v.which) !== 1'b0 && cyc < 400) begin
         @(negedge clk);
         cyc++;
      end
      check({v.name, "_length"}, cyc, v.nBits * DIV);
      repeat (3) @(negedge clk);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0]  burst [6];
      logic [2:0]  expCount [6];
      logic        expReady [6];
      logic [10:0] lineBits;
      int          cyc;
      logic        allIdle;

      vecs[0] = '{0, 8'hA5, 2'b00, 10, 11'b11101001010, "8n1_a5"};
      vecs[1] = '{0, 8'h03, 2'b10, 11, 11'b10000000110, "even_03"};
      vecs[2] = '{0, 8'h03, 2'b01, 11, 11'b11000000110, "odd_03"};
      vecs[3] = '{0, 8'h00, 2'b00, 10, 11'b11000000000, "8n1_00"};
      vecs[4] = '{0, 8'hFF, 2'b01, 11, 11'b11111111110, "odd_ff"};
      vecs[5] = '{0, 8'h80, 2'b10, 11, 11'b11100000000, "even_80"};
      vecs[6] = '{0, 8'h5A, 2'b11, 10, 11'b11010110100, "mode11_5a"};
      vecs[7] = '{0, 8'h01, 2'b01, 11, 11'b10000000010, "odd_01"};
      vecs[8] = '{1, 8'h7F, 2'b00, 10, 11'b11111111110, "7n2_7f"};
      vecs[9] = '{1, 8'h00, 2'b00, 10, 11'b11100000000, "7n2_00"};

      burst    = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
      expCount = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
      expReady = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

      rst = 1'b1;
      txValidA = 1'b0; txDataA = '0; parityModeA = 2'b00;
      txValidB = 1'b0; txDataB = '0; parityModeB = 2'b00;

      // Reset and idle
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check("rst_txd", txdA, 1'b1);
      check("rst_busy", busyA, 1'b0);
      check("rst_ready", txReadyA, 1'b1);
      check("rst_count", countA, 3'd0);
      check("rst_txd_b", txdB, 1'b1);
      repeat (20) @(negedge clk);
      check("idle_txd", txdA, 1'b1);
      check("idle_busy", busyA, 1'b0);
      check("idle_ready", txReadyA, 1'b1);
      check("idle_count", countA, 3'd0);

      for (int v = 0; v < 10; v++) begin
         runVec(vecs[v]);
      end

      // Burst of six writes on consecutive cycles; the sixth hits a full FIFO
      parityModeA = 2'b00;
      @(negedge clk);
      for (int j = 0; j < 6; j++) begin
         txDataA  = burst[j];
         txValidA = 1'b1;
         @(negedge clk);
         check($sformatf("burst_count%0d", j), countA, expCount[j]);
         check($sformatf("burst_ready%0d", j), txReadyA, expReady[j]);
         if (j == 2) begin
            check("burst_first_fall", txdA, 1'b0);
         end
      end
      txValidA = 1'b0;
      cyc = 3;
      for (int f = 0; f < 5; f++) begin
         lineBits = {2'b11, burst[f], 1'b0};
         for (int i = 0; i < 10; i++) begin
            while (cyc < f * 100 + i * DIV + 5) begin
               @(negedge clk);
               cyc++;
            end
            check($sformatf("burst_f%0d_bit%0d", f, i), txdA, lineBits[i]);
            check($sformatf("burst_f%0d_busy%0d", f, i), busyA, 1'b1);
         end
      end
      while (busyA !== 1'b0 && cyc < 700) begin
         @(negedge clk);
         cyc++;
      end
      check("burst_total_len", cyc, 500);
      check("burst_end_count", countA, 3'd0);
      check("burst_end_ready", txReadyA, 1'b1);
      allIdle = 1'b1;
      repeat (150) begin
         @(negedge clk);
         if (txdA !== 1'b1 || busyA !== 1'b0) allIdle = 1'b0;
      end
      check("burst_sixth_dropped", allIdle, 1'b1);

      // Reset during data bit 3 with two words queued
      @(negedge clk);
      txDataA = 8'h00; txValidA = 1'b1;
      @(negedge clk);
      txDataA = 8'hC3;
      @(negedge clk);
      txDataA = 8'h3C;
      @(negedge clk);
      txValidA = 1'b0;
      check("rmf_fall", txdA, 1'b0);
      check("rmf_queued", countA, 3'd2);
      cyc = 0;
      while (cyc < 45) begin
         @(negedge clk);
         cyc++;
      end
      check("rmf_pre_txd", txdA, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      check("rmf_txd", txdA, 1'b1);
      check("rmf_count", countA, 3'd0);
      check("rmf_busy", busyA, 1'b0);
      check("rmf_ready", txReadyA, 1'b1);
      rst = 1'b0;
      allIdle = 1'b1;
      repeat (300) begin
         @(negedge clk);
         if (txdA !== 1'b1 || busyA !== 1'b0 || countA !== 3'd0) allIdle = 1'b0;
      end
      check("rmf_no_more_frames", allIdle, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
